// File: rtl/matrix_scan_capture.sv
// Captures an externally scanned 8x8 key/LED matrix into a 64-bit frame register.
// Rows must arrive in order 0..7, each held long enough to settle, to form a frame.
module matrix_scan_capture #(
   parameter int unsigned SETTLE = 4,
   parameter bit          INVERT = 1'b0
) (
   input  logic        i_sys_clock,
   input  logic        i_sys_reset,
   input  logic [2:0]  i_row,
   input  logic [7:0]  i_col,
   output logic [63:0] o_frame,
   output logic        o_frame_valid,
   input  logic        i_frame_ready,
   output logic [15:0] o_frame_count,
   output logic        o_seq_error,
   output logic        o_overrun
);

   typedef enum logic [0:0] {StHunt, StAccum} state_e;

   localparam logic [7:0] SettleMax  = 8'(SETTLE);
   localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

   logic [2:0]  r_row_s1, r_row_s2, r_row_prev;
   logic [7:0]  r_col_s1, r_col_s2;
   logic [7:0]  r_settle;
   logic [63:0] r_shadow;
   logic [63:0] r_frame;
   logic        r_frame_valid;
   logic [15:0] r_frame_count;
   logic        r_seq_error;
   logic        r_overrun;
   logic [2:0]  r_expected;
   state_e      r_state;

   logic        w_row_changed;
   logic        w_sample;
   logic [7:0]  w_data;
   logic        w_store;
   logic        w_complete;
   logic        w_seq_err;
   logic        w_load;
   logic [2:0]  w_expected_d;
   state_e      w_state_d;

   assign w_row_changed = (r_row_s2 != r_row_prev);
   // Counter saturates at SETTLE, so the SETTLE-1 value is seen once per dwell.
   assign w_sample      = !w_row_changed && (r_settle == SettleLast);
   assign w_data        = r_col_s2 ^ {8{INVERT}};
   assign w_load        = w_complete && (!r_frame_valid || i_frame_ready);

   always_comb begin
      w_state_d    = r_state;
      w_expected_d = r_expected;
      w_store      = 1'b0;
      w_complete   = 1'b0;
      w_seq_err    = 1'b0;
      if (w_sample) begin
         unique case (r_state)
            StHunt: begin
               if (r_row_s2 == 3'd0) begin
                  w_store      = 1'b1;
                  w_expected_d = 3'd1;
                  w_state_d    = StAccum;
               end
            end
            StAccum: begin
               if (r_row_s2 == r_expected) begin
                  w_store = 1'b1;
                  if (r_row_s2 == 3'd7) begin
                     w_complete   = 1'b1;
                     w_expected_d = 3'd0;
                     w_state_d    = StHunt;
                  end else begin
                     w_expected_d = r_expected + 3'd1;
                  end
               end else begin
                  w_seq_err = 1'b1;
                  if (r_row_s2 == 3'd0) begin
                     w_store      = 1'b1;
                     w_expected_d = 3'd1;
                     w_state_d    = StAccum;
                  end else begin
                     w_expected_d = 3'd0;
                     w_state_d    = StHunt;
                  end
               end
            end
            default: begin
               w_expected_d = 3'd0;
               w_state_d    = StHunt;
            end
         endcase
      end
   end

   always_ff @(posedge i_sys_clock) begin
      if (i_sys_reset) begin
         r_row_s1      <= '0;
         r_row_s2      <= '0;
         r_row_prev    <= '0;
         r_col_s1      <= '0;
         r_col_s2      <= '0;
         r_settle      <= '0;
         r_shadow      <= '0;
         r_frame       <= '0;
         r_frame_valid <= 1'b0;
         r_frame_count <= '0;
         r_seq_error   <= 1'b0;
         r_overrun     <= 1'b0;
         r_expected    <= '0;
         r_state       <= StHunt;
      end else begin
         r_row_s1   <= i_row;
         r_row_s2   <= r_row_s1;
         r_col_s1   <= i_col;
         r_col_s2   <= r_col_s1;
         r_row_prev <= r_row_s2;
         if (w_row_changed) begin
            r_settle <= '0;
         end else if (r_settle != SettleMax) begin
            r_settle <= r_settle + 8'd1;
         end
         if (w_store) begin
            r_shadow[{r_row_s2, 3'b000} +: 8] <= w_data;
         end
         // Row 7 is merged in directly so the frame lands one cycle after its sample.
         if (w_load) begin
            r_frame       <= {w_data, r_shadow[55:0]};
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
         end else if (r_frame_valid && i_frame_ready) begin
            r_frame_valid <= 1'b0;
         end
         r_seq_error <= w_seq_err;
         r_overrun   <= w_complete && r_frame_valid && !i_frame_ready;
         r_expected  <= w_expected_d;
         r_state     <= w_state_d;
      end
   end

   assign o_frame       = r_frame;
   assign o_frame_valid = r_frame_valid;
   assign o_frame_count = r_frame_count;
   assign o_seq_error   = r_seq_error;
   assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture: one normal and one inverting instance
// share the scan stimulus.
module tb_matrix_scan_capture;

   logic        clk;
   logic        rst;
   logic [2:0]  row;
   logic [7:0]  col;
   logic        ready;

   logic [63:0] frame,     frame_i;
   logic        valid,     valid_i;
   logic [15:0] count,     count_i;
   logic        seq_error, seq_error_i;
   logic        overrun,   overrun_i;

   int errors = 0;
   int checks = 0;
   int seq_cnt = 0;
   int ovr_cnt = 0;
   int vld_cnt = 0;

   matrix_scan_capture #(.SETTLE(4), .INVERT(1'b0)) dut (
      .i_sys_clock  (clk),
      .i_sys_reset  (rst),
      .i_row        (row),
      .i_col        (col),
      .o_frame      (frame),
      .o_frame_valid(valid),
      .i_frame_ready(ready),
      .o_frame_count(count),
      .o_seq_error  (seq_error),
      .o_overrun    (overrun)
   );

   matrix_scan_capture #(.SETTLE(4), .INVERT(1'b1)) dut_inv (
      .i_sys_clock  (clk),
      .i_sys_reset  (rst),
      .i_row        (row),
      .i_col        (col),
      .o_frame      (frame_i),
      .o_frame_valid(valid_i),
      .i_frame_ready(ready),
      .o_frame_count(count_i),
      .o_seq_error  (seq_error_i),
      .o_overrun    (overrun_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (seq_error) seq_cnt <= seq_cnt + 1;
      if (overrun)   ovr_cnt <= ovr_cnt + 1;
      if (valid)     vld_cnt <= vld_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required below 300000", $time);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      row = 3'd7;
      col = 8'h00;
      tick(2);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic scan_row(input logic [2:0] r, input logic [7:0] c, input int dwell);
      row = r;
      col = c;
      tick(dwell);
   endtask

   task automatic scan_frame(input logic [63:0] data);
      for (int r = 0; r < 8; r++) scan_row(3'(r), data[8*r +: 8], 10);
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      row   = 3'd7;
      col   = 8'hFF;
      ready = 1'b0;
      tick(3);
      checks++; if (frame !== 64'h0) begin errors++; $display("FAIL reset_frame got=%h exp=0", frame); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
      checks++; if (seq_error !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL reset_pulses got=%b%b exp=00", seq_error, overrun);
      end
      checks++; if ({frame_i, valid_i, count_i, seq_error_i, overrun_i} !== '0) begin
         errors++; $display("FAIL reset_inv got frame=%h count=%h exp=0", frame_i, count_i);
      end
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_basic;
      logic [63:0] pat;
      int          vbase;
      pat = 64'h8040201008040201;
      do_reset();
      ready = 1'b1;
      vbase = vld_cnt;
      for (int r = 0; r < 7; r++) scan_row(3'(r), pat[8*r +: 8], 10);
      row = 3'd7;
      col = 8'h80;
      tick(6);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", valid); end
      tick(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got=%b exp=1", valid); end
      checks++; if (frame !== pat) begin errors++; $display("FAIL basic_frame got=%h exp=%h", frame, pat); end
      tick(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", valid); end
      tick(2);
      checks++; if (count !== 16'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", count); end
      checks++; if (vld_cnt - vbase !== 1) begin
         errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", vld_cnt - vbase);
      end
      checks++; if (frame_i !== 64'h7FBFDFEFF7FBFDFE) begin
         errors++; $display("FAIL basic_inv_frame got=%h exp=7fbfdfeff7fbfdfe", frame_i);
      end
   endtask

   task automatic test_invert;
      logic [63:0] pat;
      pat = {8{8'hFE}};
      do_reset();
      ready = 1'b1;
      scan_frame(pat);
      checks++; if (frame_i !== {8{8'h01}}) begin
         errors++; $display("FAIL invert_frame got=%h exp=0101010101010101", frame_i);
      end
      checks++; if (frame !== pat) begin errors++; $display("FAIL invert_plain got=%h exp=%h", frame, pat); end
      checks++; if (count_i !== 16'd1) begin errors++; $display("FAIL invert_count got=%0d exp=1", count_i); end
   endtask

   task automatic test_seq_error;
      logic [63:0] pat;
      int          sbase;
      pat = 64'h1122334455667788;
      do_reset();
      ready = 1'b1;
      sbase = seq_cnt;
      scan_row(3'd0, 8'hAA, 10);
      scan_row(3'd1, 8'hBB, 10);
      scan_row(3'd2, 8'hCC, 10);
      row = 3'd5;
      col = 8'hDD;
      tick(7);
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL seq_pulse got=%b exp=1", seq_error); end
      tick(1);
      checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL seq_pulse_end got=%b exp=0", seq_error); end
      tick(2);
      checks++; if (seq_cnt - sbase !== 1) begin
         errors++; $display("FAIL seq_count got=%0d exp=1", seq_cnt - sbase);
      end
      checks++; if (count !== 16'd0 || valid !== 1'b0) begin
         errors++; $display("FAIL seq_no_frame got count=%0d valid=%b exp=0 0", count, valid);
      end
      scan_frame(pat);
      checks++; if (count !== 16'd1) begin errors++; $display("FAIL seq_recover_count got=%0d exp=1", count); end
      checks++; if (frame !== pat) begin errors++; $display("FAIL seq_recover_frame got=%h exp=%h", frame, pat); end
   endtask

   task automatic test_overrun;
      logic [63:0] pa, pb;
      int          obase;
      pa = 64'h8040201008040201;
      pb = 64'hDEADBEEFCAFEF00D;
      do_reset();
      ready = 1'b0;
      scan_frame(pa);
      checks++; if (valid !== 1'b1 || frame !== pa) begin
         errors++; $display("FAIL ovr_first got valid=%b frame=%h exp=1 %h", valid, frame, pa);
      end
      obase = ovr_cnt;
      for (int r = 0; r < 7; r++) scan_row(3'(r), pb[8*r +: 8], 10);
      row = 3'd7;
      col = pb[63:56];
      tick(7);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
      tick(1);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end got=%b exp=0", overrun); end
      tick(2);
      checks++; if (ovr_cnt - obase !== 1) begin
         errors++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - obase);
      end
      checks++; if (frame !== pa || valid !== 1'b1) begin
         errors++; $display("FAIL ovr_hold got valid=%b frame=%h exp=1 %h", valid, frame, pa);
      end
      checks++; if (count !== 16'd1) begin errors++; $display("FAIL ovr_frame_count got=%0d exp=1", count); end
      ready = 1'b1;
      tick(1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", valid); end
   endtask

   task automatic test_short_dwell;
      int sbase;
      do_reset();
      ready = 1'b1;
      sbase = seq_cnt;
      scan_row(3'd0, 8'h10, 10);
      scan_row(3'd1, 8'h11, 10);
      scan_row(3'd2, 8'h12, 10);
      scan_row(3'd3, 8'h13, 3);
      row = 3'd4;
      col = 8'h14;
      tick(7);
      checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL short_pulse got=%b exp=1", seq_error); end
      tick(3);
      scan_row(3'd5, 8'h15, 10);
      scan_row(3'd6, 8'h16, 10);
      scan_row(3'd7, 8'h17, 10);
      checks++; if (seq_cnt - sbase !== 1) begin
         errors++; $display("FAIL short_seq_count got=%0d exp=1", seq_cnt - sbase);
      end
      checks++; if (count !== 16'd0 || valid !== 1'b0) begin
         errors++; $display("FAIL short_no_frame got count=%0d valid=%b exp=0 0", count, valid);
      end
   endtask

   task automatic test_wrap_and_reset;
      logic [63:0] pp, pq;
      int          vbase;
      pp = 64'h0F1E2D3C4B5A6978;
      pq = 64'h0102040810204080;
      do_reset();
      ready = 1'b1;
      force dut.r_frame_count = 16'hFFFF;
      tick(1);
      release dut.r_frame_count;
      scan_frame(pp);
      checks++; if (count !== 16'h0000) begin errors++; $display("FAIL wrap_count got=%h exp=0000", count); end
      checks++; if (frame !== pp) begin errors++; $display("FAIL wrap_frame got=%h exp=%h", frame, pp); end
      for (int r = 0; r < 4; r++) scan_row(3'(r), pq[8*r +: 8], 10);
      row = 3'd4;
      col = pq[39:32];
      tick(3);
      rst = 1'b1;
      tick(1);
      checks++; if ({frame, valid, count, seq_error, overrun} !== '0) begin
         errors++; $display("FAIL midreset_outputs got frame=%h valid=%b count=%h exp=0", frame, valid, count);
      end
      rst = 1'b0;
      vbase = vld_cnt;
      tick(6);
      for (int r = 5; r < 8; r++) scan_row(3'(r), pq[8*r +: 8], 10);
      checks++; if (vld_cnt - vbase !== 0 || count !== 16'd0 || frame !== 64'h0) begin
         errors++; $display("FAIL midreset_no_frame got valid_cycles=%0d count=%0d frame=%h exp=0",
                            vld_cnt - vbase, count, frame);
      end
      scan_frame(pq);
      checks++; if (count !== 16'd1 || frame !== pq) begin
         errors++; $display("FAIL midreset_recover got count=%0d frame=%h exp=1 %h", count, frame, pq);
      end
   endtask

   initial begin
      rst   = 1'b1;
      row   = 3'd7;
      col   = 8'h00;
      ready = 1'b0;
      test_reset();
      test_basic();
      test_invert();
      test_seq_error();
      test_overrun();
      test_short_dwell();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matrix_scan_capture.md
MATRIX_SCAN_CAPTURE -- requirements
Module: matrix_scan_capture

Interface
REQ-001 Parameter SETTLE, default 4, meaning cycles a synchronized row value must hold before col is sampled (legal 1..255).
REQ-002 Parameter INVERT, default 0, meaning when 1 captured col bits are inverted before storage.
REQ-003 sys_clock  input  1  sole clock; all logic on rising edge.
REQ-004 sys_reset  input  1  synchronous, active-high reset.
REQ-005 row  input  3  scanned row select from matrix driver, asynchronous to sys_clock.
REQ-006 col  input  8  column pattern for current row, asynchronous to sys_clock.
REQ-007 frame  output  64  last complete frame; row r occupies bits [8r+7:8r].
REQ-008 frame_valid  output  1  frame holds an unconsumed complete frame.
REQ-009 frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-010 frame_count  output  16  number of frames handed to frame register.
REQ-011 seq_error  output  1  one-cycle pulse on out-of-order row.
REQ-012 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-013 row and col SHALL each pass through a 2-flop synchronizer; all further logic uses synchronized values (rs, cs).
REQ-014 Settle counter SHALL clear to 0 on any cycle rs differs from its previous-cycle value, else increment, saturating at SETTLE.
REQ-015 Sample event SHALL occur exactly once per row dwell: on the cycle counter transitions from SETTLE-1 to SETTLE.
REQ-016 Sample SHALL write cs (XOR {8{INVERT}}) into shadow[rs].
REQ-017 FSM states SHALL be HUNT and ACCUM; reset state HUNT.
REQ-018 HUNT: sample with rs==0 SHALL store row 0, set expected=1, go to ACCUM; samples of rows 1..7 ignored, no error.
REQ-019 ACCUM: sample with rs==expected SHALL store and increment expected; sample of row 7 completes the frame and returns to HUNT.
REQ-020 ACCUM: sample with rs!=expected SHALL pulse seq_error one cycle, discard partial frame; if rs==0 restart ACCUM with expected=1, else go to HUNT.
REQ-021 On frame completion, if frame_valid==0 or frame_ready==1 in that cycle, shadow (including row 7 just sampled) SHALL load into frame next cycle, frame_valid=1, frame_count+=1.
REQ-022 On completion while frame_valid==1 and frame_ready==0, frame SHALL be unchanged, frame_count unchanged, overrun pulses one cycle.
REQ-023 frame_valid SHALL clear the cycle after frame_valid&&frame_ready with no simultaneous load; simultaneous accept and load keeps frame_valid=1.
REQ-024 frame and frame_valid SHALL not change while frame_valid==1 and frame_ready==0.
REQ-025 frame_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-026 Latency: col change to frame update = 2 sync + SETTLE + 1 cycles minimum for row 7.

Reset
REQ-027 sys_reset high SHALL set: frame=0, frame_valid=0, frame_count=0, seq_error=0, overrun=0, shadow=0, settle counter=0, synchronizers=0, FSM=HUNT, expected=0.
REQ-028 sys_reset mid-frame SHALL discard partial frame; first frame after reset requires a full row 0..7 sequence.
REQ-029 sys_reset has priority over all other events in the same cycle.

Verification
REQ-030 Scan rows 0..7 ascending, 10 cycles each, col=8'h01<<r, frame_ready=1 -> frame=64'h8040201008040201, frame_valid=1 one cycle, frame_count=1.
REQ-031 Same scan with INVERT=1, col=8'hFE -> every byte of frame = 8'h01.
REQ-032 Scan 0,1,2,5 -> seq_error pulse at row 5 sample, FSM HUNT, frame_count unchanged; following clean 0..7 scan -> frame_count=1.
REQ-033 frame_ready=0, two complete scans -> frame holds first scan data, overrun pulses once, frame_count=1; raise frame_ready -> frame_valid drops next cycle.
REQ-034 Row dwell of SETTLE-1 cycles (3) on row 3 within a scan -> row 3 not sampled, row 4 sample raises seq_error.
REQ-035 Preload frame_count=16'hFFFF via 65535 scans (or forced) then one scan -> frame_count=16'h0000; sys_reset asserted at row 4 -> all outputs zero, no frame produced until next row 0.
